instruction_sequencer: RTL and testbench

- Control stage directly upstream of the register file.
- Fetches the 12-bit opcode from program ROM at the register file's PC and paces micro-ops through CYCLE_REG_FETCH / CYCLE_REG_WRITE.
- Pads each instruction to its native clock count (5/7/12), issues the PC-increment and NP-reset strobes, and handles HALT and interrupt entry at instruction boundaries.
- Decoder and microcode ROM are external: they map opcode/micro_index to selectors and report micro-op count and instruction length.

---
 rtl/instruction_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches opcodes, paces micro-op fetch/write pairs, pads each
// instruction to its native clock count and handles HALT and interrupt entry at boundaries.

package instruction_sequencer_pkg;
    typedef enum logic [1:0] {
        CYCLE_NONE      = 2'd0,
        CYCLE_REG_FETCH = 2'd1,
        CYCLE_REG_WRITE = 2'd2
    } microcode_cycle;
endpackage

module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int MAX_MICRO = 6,
    parameter int CNT_W     = 4,
    localparam int MI_W     = $clog2(MAX_MICRO + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_en,
    input  logic [12:0]         pc,
    output logic [12:0]         rom_addr,
    input  logic [11:0]         rom_data,
    input  logic [2:0]          decode_micro_count,
    input  logic [3:0]          decode_cycles,
    input  logic                interrupt_req,
    input  logic                interrupt_flag,
    output logic [11:0]         opcode,
    output microcode_cycle      current_cycle,
    output logic [MI_W-1:0]     micro_index,
    output logic                in_interrupt,
    output logic                increment_pc,
    output logic                reset_np,
    output logic                halted,
    output logic                instr_done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MFETCH = 3'd2,
        S_MWRITE = 3'd3,
        S_WAIT   = 3'd4,
        S_HALT   = 3'd5,
        S_INT    = 3'd6
    } state_t;

    localparam int INT_PAIRS = 4;
    localparam int INT_TICKS = 12;

    localparam logic [11:0] OP_HALT = 12'hFF8;
    localparam logic [11:0] OP_SLP  = 12'hFFB;
    localparam logic [7:0]  OP_PSET = 8'hE4;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [11:0]      opcode_q, opcode_d;
    logic [MI_W-1:0]  micro_index_q, micro_index_d;
    logic [MI_W-1:0]  micro_count_q, micro_count_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic [MI_W-1:0]  dec_count;
    logic [CNT_W-1:0] dec_cycles;
    logic [11:0]      final_op;
    logic             final_tick;
    logic             irq_taken;

    // Out-of-range decoder reports are sanitised before they are latched.
    assign dec_count  = (int'(decode_micro_count) > MAX_MICRO) ? MI_W'(MAX_MICRO)
                                                               : MI_W'(decode_micro_count);
    assign dec_cycles = (decode_cycles < 4'd2) ? CNT_W'(2) : CNT_W'(decode_cycles);

    // In DECODE the opcode is still on the ROM bus, so boundary decisions read it there.
    assign final_op  = (state_q == S_DECODE) ? rom_data : opcode_q;
    assign irq_taken = interrupt_req && interrupt_flag;

    assign rom_addr     = pc;
    assign opcode       = opcode_q;
    assign micro_index  = micro_index_q;
    assign halted       = (state_q == S_HALT);
    assign in_interrupt = (state_q == S_INT);

    always_comb begin
        current_cycle = CYCLE_NONE;
        unique case (state_q)
            S_MFETCH: current_cycle = CYCLE_REG_FETCH;
            S_MWRITE: current_cycle = CYCLE_REG_WRITE;
            S_INT: begin
                if (counter_q < CNT_W'(2 * INT_PAIRS))
                    current_cycle = counter_q[0] ? CYCLE_REG_WRITE : CYCLE_REG_FETCH;
            end
            default: current_cycle = CYCLE_NONE;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        counter_d     = counter_q;
        opcode_d      = opcode_q;
        micro_index_d = micro_index_q;
        micro_count_d = micro_count_q;
        cycles_d      = cycles_q;
        increment_pc  = 1'b0;
        reset_np      = 1'b0;
        instr_done    = 1'b0;
        final_tick    = 1'b0;

        if (clk_en) begin
            counter_d = counter_q + CNT_W'(1);
            unique case (state_q)
                S_FETCH: begin
                    counter_d = CNT_W'(1);
                    state_d   = S_DECODE;
                end
                S_DECODE: begin
                    opcode_d      = rom_data;
                    micro_count_d = dec_count;
                    cycles_d      = dec_cycles;
                    increment_pc  = 1'b1;
                    if (dec_count != '0)
                        state_d = S_MFETCH;
                    else if (counter_q >= dec_cycles - CNT_W'(1))
                        final_tick = 1'b1;
                    else
                        state_d = S_WAIT;
                end
                S_MFETCH: state_d = S_MWRITE;
                S_MWRITE: begin
                    if (micro_index_q == micro_count_q - MI_W'(1)) begin
                        micro_index_d = '0;
                        // Micro-ops that overrun the native length end the instruction here.
                        if (counter_q >= cycles_q - CNT_W'(1))
                            final_tick = 1'b1;
                        else
                            state_d = S_WAIT;
                    end else begin
                        micro_index_d = micro_index_q + MI_W'(1);
                        state_d       = S_MFETCH;
                    end
                end
                S_WAIT: begin
                    if (counter_q >= cycles_q - CNT_W'(1))
                        final_tick = 1'b1;
                end
                S_HALT: begin
                    counter_d = '0;
                    if (irq_taken)
                        state_d = S_INT;
                end
                S_INT: begin
                    if (counter_q < CNT_W'(2 * INT_PAIRS) && counter_q[0])
                        micro_index_d = (micro_index_q == MI_W'(INT_PAIRS - 1))
                                        ? '0 : micro_index_q + MI_W'(1);
                    if (counter_q == CNT_W'(INT_TICKS - 1)) begin
                        reset_np  = 1'b1;
                        counter_d = '0;
                        state_d   = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase

            if (final_tick) begin
                instr_done = 1'b1;
                // PSET leaves NP alone so its page survives into the next instruction.
                reset_np   = (final_op[11:4] != OP_PSET);
                counter_d  = '0;
                if (irq_taken)
                    state_d = S_INT;
                else if (final_op == OP_HALT || final_op == OP_SLP)
                    state_d = S_HALT;
                else
                    state_d = S_FETCH;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_FETCH;
            counter_q     <= '0;
            opcode_q      <= '0;
            micro_index_q <= '0;
            micro_count_q <= '0;
            cycles_q      <= CNT_W'(2);
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            opcode_q      <= opcode_d;
            micro_index_q <= micro_index_d;
            micro_count_q <= micro_count_d;
            cycles_q      <= cycles_d;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: a per-instruction trace model checked
// every clk, plus hand-computed tick expectations for the directed program.

module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           clk_en;
    logic [12:0]    pc = 13'd0;
    logic [12:0]    rom_addr;
    logic [11:0]    rom_data = 12'h000;
    logic [2:0]     decode_micro_count;
    logic [3:0]     decode_cycles;
    logic           interrupt_req;
    logic           interrupt_flag;
    logic [11:0]    opcode;
    microcode_cycle current_cycle;
    logic [2:0]     micro_index;
    logic           in_interrupt;
    logic           increment_pc;
    logic           reset_np;
    logic           halted;
    logic           instr_done;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_no  = 0;

    logic [11:0] rom_mem [0:8191];

    microcode_cycle log_cycle [0:511];
    logic [2:0]     log_mi    [0:511];
    logic           log_inc   [0:511];
    logic           log_rnp   [0:511];
    logic           log_done  [0:511];
    logic           log_halt  [0:511];
    logic           log_int   [0:511];

    instruction_sequencer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .clk_en             (clk_en),
        .pc                 (pc),
        .rom_addr           (rom_addr),
        .rom_data           (rom_data),
        .decode_micro_count (decode_micro_count),
        .decode_cycles      (decode_cycles),
        .interrupt_req      (interrupt_req),
        .interrupt_flag     (interrupt_flag),
        .opcode             (opcode),
        .current_cycle      (current_cycle),
        .micro_index        (micro_index),
        .in_interrupt       (in_interrupt),
        .increment_pc       (increment_pc),
        .reset_np           (reset_np),
        .halted             (halted),
        .instr_done         (instr_done)
    );

    always #5 clk = ~clk;

    // Decoder table: {micro_count, cycles} as reported by the external decoder.
    function automatic logic [6:0] dec_lookup(input logic [11:0] op);
        case (op)
            12'hFFF: return {3'd0, 4'd5};
            12'h120: return {3'd1, 4'd5};
            12'hE41: return {3'd0, 4'd5};
            12'h400: return {3'd2, 4'd7};
            12'h500: return {3'd6, 4'd12};
            12'h600: return {3'd7, 4'd12};
            12'h601: return {3'd0, 4'd1};
            12'h700: return {3'd3, 4'd5};
            default: return {3'd0, 4'd5};
        endcase
    endfunction

    assign {decode_micro_count, decode_cycles} = dec_lookup(rom_data);

    // Environment: synchronous ROM and the register file's PC.
    always @(posedge clk) begin
        rom_data <= rom_mem[rom_addr];
        if (increment_pc)
            pc <= pc + 13'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model: mode 0 = instruction, 1 = halted, 2 = interrupt entry; k = enabled tick within it.
    int          m_mode = 0;
    int          m_k    = 0;
    int          m_n    = 0;
    int          m_len  = 2;
    logic [11:0] m_op   = 12'h000;
    logic [11:0] exp_opcode = 12'h000;

    always @(negedge clk) begin : model
        microcode_cycle e_cycle;
        int  e_mi, cur, raw_n, raw_c;
        logic e_inc, e_rnp, e_done, e_halt, e_int, fin, en;
        logic [6:0] d;

        en = clk_en && reset_n;
        if (!reset_n) begin
            m_mode = 0; m_k = 0; exp_opcode = 12'h000;
        end else if (m_mode == 0 && m_k == 1) begin
            m_op  = rom_mem[pc];
            d     = dec_lookup(m_op);
            raw_n = int'(d[6:4]);
            raw_c = int'(d[3:0]);
            m_n   = (raw_n > 6) ? 6 : raw_n;
            raw_c = (raw_c < 2) ? 2 : raw_c;
            m_len = (raw_c > 2 + 2 * m_n) ? raw_c : 2 + 2 * m_n;
        end

        e_cycle = CYCLE_NONE; e_mi = 0; e_inc = 0; e_rnp = 0; e_done = 0;
        e_halt = 0; e_int = 0; fin = 0;
        case (m_mode)
            0: begin
                if (m_k >= 2 && m_k < 2 + 2 * m_n) begin
                    e_cycle = (m_k % 2 == 0) ? CYCLE_REG_FETCH : CYCLE_REG_WRITE;
                    e_mi    = (m_k - 2) / 2;
                end
                fin    = (m_k >= 1) && (m_k == m_len - 1);
                e_inc  = clk_en && (m_k == 1);
                e_done = clk_en && fin;
                e_rnp  = e_done && (m_op[11:4] != 8'hE4);
            end
            1: e_halt = 1;
            default: begin
                e_int = 1;
                if (m_k < 8) begin
                    e_cycle = (m_k % 2 == 0) ? CYCLE_REG_FETCH : CYCLE_REG_WRITE;
                    e_mi    = m_k / 2;
                end
                e_rnp = clk_en && (m_k == 11);
            end
        endcase

        cur = tick_no + 1;
        check($sformatf("cycle@%0d", cur), 32'(current_cycle), 32'(e_cycle));
        check($sformatf("micro_index@%0d", cur), 32'(micro_index), 32'(e_mi));
        check($sformatf("increment_pc@%0d", cur), 32'(increment_pc), 32'(e_inc));
        check($sformatf("reset_np@%0d", cur), 32'(reset_np), 32'(e_rnp));
        check($sformatf("instr_done@%0d", cur), 32'(instr_done), 32'(e_done));
        check($sformatf("halted@%0d", cur), 32'(halted), 32'(e_halt));
        check($sformatf("in_interrupt@%0d", cur), 32'(in_interrupt), 32'(e_int));
        check($sformatf("opcode@%0d", cur), 32'(opcode), 32'(exp_opcode));
        check($sformatf("rom_addr@%0d", cur), 32'(rom_addr), 32'(pc));

        if (en && cur < 512) begin
            log_cycle[cur] = current_cycle;
            log_mi[cur]    = micro_index;
            log_inc[cur]   = increment_pc;
            log_rnp[cur]   = reset_np;
            log_done[cur]  = instr_done;
            log_halt[cur]  = halted;
            log_int[cur]   = in_interrupt;
        end

        if (en) begin
            tick_no++;
            case (m_mode)
                0: begin
                    if (m_k == 1)
                        exp_opcode = m_op;
                    if (fin) begin
                        m_k = 0;
                        if (interrupt_req && interrupt_flag)
                            m_mode = 2;
                        else if (m_op == 12'hFF8 || m_op == 12'hFFB)
                            m_mode = 1;
                        else
                            m_mode = 0;
                    end else begin
                        m_k++;
                    end
                end
                1: if (interrupt_req && interrupt_flag) begin
                    m_mode = 2; m_k = 0;
                end
                default: begin
                    if (m_k == 11) begin
                        m_mode = 0; m_k = 0;
                    end else begin
                        m_k++;
                    end
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int target, input string name);
        int guard = 0;
        while (tick_no < target && guard < 400) begin
            step();
            guard++;
        end
        if (tick_no < target)
            check({"timeout_", name}, 32'(tick_no), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tick %0d", tick_no);
        $fatal(1);
    end

    initial begin : stim
        int h, guard, inc_sum;
        logic [11:0] prog [0:12];

        for (int i = 0; i < 8192; i++) rom_mem[i] = 12'hFFF;
        prog = '{12'hFFF, 12'h120, 12'hE41, 12'h400, 12'h500, 12'h600, 12'h601,
                 12'h700, 12'hFF8, 12'hFFB, 12'h500, 12'hFFF, 12'hFFF};
        for (int i = 0; i < 13; i++) rom_mem[i] = prog[i];

        reset_n        = 1'b0;
        clk_en         = 1'b1;
        interrupt_req  = 1'b1;
        interrupt_flag = 1'b0;
        repeat (3) step();

        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_cycle", 32'(current_cycle), 32'(CYCLE_NONE));
        check("rst_micro_index", 32'(micro_index), 32'h0);
        check("rst_strobes", {29'd0, increment_pc, reset_np, instr_done}, 32'h0);
        check("rst_halted_int", {30'd0, halted, in_interrupt}, 32'h0);
        reset_n = 1'b1;

        // Through JP, then pace the 6-micro-op instruction with clk_en 1-in-4.
        wait_tick(22, "jp_end");
        for (int i = 0; i < 56; i++) begin
            clk_en = (i % 4 == 3);
            step();
        end
        clk_en = 1'b1;
        check("gated_tick_count", 32'(tick_no), 32'd36);

        // HALT with the I flag clear must not wake.
        guard = 0;
        while (!halted && guard < 200) begin
            step();
            guard++;
        end
        check("halt_reached", 32'(halted), 32'd1);
        repeat (5) step();
        check("halt_holds_flag_clear", 32'(halted), 32'd1);
        h = tick_no;
        interrupt_flag = 1'b1;

        wait_tick(h + 19, "slp_int");
        interrupt_req = 1'b0;

        // Abandon the 12-cycle instruction during its second MWRITE.
        wait_tick(h + 35, "mwrite");
        #2;
        check("pre_reset_cycle", 32'(current_cycle), 32'(CYCLE_REG_WRITE));
        check("pre_reset_micro_index", 32'(micro_index), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_cycle", 32'(current_cycle), 32'(CYCLE_NONE));
        check("async_rst_micro_index", 32'(micro_index), 32'd0);
        check("async_rst_opcode", 32'(opcode), 32'h0);
        repeat (2) step();
        reset_n = 1'b1;
        check("post_reset_pc", 32'(pc), 32'd11);
        check("post_reset_rom_addr", 32'(rom_addr), 32'd11);
        repeat (12) step();

        check("nop_inc_t1", 32'(log_inc[1]), 32'd0);
        check("nop_inc_t2", 32'(log_inc[2]), 32'd1);
        check("nop_done_t5", 32'(log_done[5]), 32'd1);
        check("nop_rnp_t5", 32'(log_rnp[5]), 32'd1);
        check("ld_cycle_t7", 32'(log_cycle[7]), 32'(CYCLE_NONE));
        check("ld_cycle_t8", 32'(log_cycle[8]), 32'(CYCLE_REG_FETCH));
        check("ld_cycle_t9", 32'(log_cycle[9]), 32'(CYCLE_REG_WRITE));
        check("ld_cycle_t10", 32'(log_cycle[10]), 32'(CYCLE_NONE));
        check("ld_mi_t9", 32'(log_mi[9]), 32'd0);
        check("ld_next_decode_t12", 32'(log_inc[12]), 32'd1);
        check("pset_done_t15", 32'(log_done[15]), 32'd1);
        check("pset_rnp_t15", 32'(log_rnp[15]), 32'd0);
        check("jp_rnp_t22", 32'(log_rnp[22]), 32'd1);
        check("m6_mi_t35", 32'(log_mi[35]), 32'd5);
        check("m6_end_cycle_t36", 32'(log_cycle[36]), 32'(CYCLE_REG_WRITE));
        check("m6_done_t36", 32'(log_done[36]), 32'd1);
        check("clamp_mi_t50", 32'(log_mi[50]), 32'd5);
        check("clamp_done_t50", 32'(log_done[50]), 32'd1);
        check("short_done_t52", 32'(log_done[52]), 32'd1);
        check("short_inc_t52", 32'(log_inc[52]), 32'd1);
        check("overrun_cycle_t60", 32'(log_cycle[60]), 32'(CYCLE_REG_WRITE));
        check("overrun_done_t60", 32'(log_done[60]), 32'd1);
        check("halt_wake_tick", 32'(log_halt[h + 1]), 32'd1);
        check("int_first", 32'(log_int[h + 2]), 32'd1);
        check("int_last", 32'(log_int[h + 13]), 32'd1);
        check("int_rnp_last", 32'(log_rnp[h + 13]), 32'd1);
        check("int_then_fetch", 32'(log_int[h + 14]), 32'd0);
        inc_sum = 0;
        for (int t = h + 2; t <= h + 13; t++) inc_sum += int'(log_inc[t]);
        check("int_no_increment_pc", 32'(inc_sum), 32'd0);
        check("slp_irq_priority_int", 32'(log_int[h + 19]), 32'd1);
        check("slp_irq_priority_halt", 32'(log_halt[h + 19]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
